// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM encoding for the serial program-memory loader.
package prog_loader_pkg;

    localparam int         PL_ADDR_W    = 10;
    localparam int         PL_DATA_W    = 18;
    localparam logic [7:0] PL_SYNC_BYTE = 8'hA5;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_CNT_HI = 4'd1;
    localparam state_t S_CNT_LO = 4'd2;
    localparam state_t S_B2     = 4'd3;
    localparam state_t S_B1     = 4'd4;
    localparam state_t S_B0     = 4'd5;
    localparam state_t S_WRITE  = 4'd6;
    localparam state_t S_CHECK  = 4'd7;
    localparam state_t S_DONE   = 4'd8;
    localparam state_t S_ERR    = 4'd9;

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte watchdog: counts while armed, restarts on each byte.
module prog_loader_timer #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    assign expired = run && (cnt == W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || clr) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream to program BRAM writer; holds the CPU in reset while loading.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
import prog_loader_pkg::*;

module prog_loader #(
    parameter int          ADDR_W         = PL_ADDR_W,
    parameter int          DATA_W         = PL_DATA_W,
    parameter logic [7:0]  SYNC_BYTE      = PL_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state;
    state_t            nxt;
    logic              acc;
    logic              is_sync;
    logic              tmo;
    logic [7:0]        sum;
    logic [7:0]        sum_chk;
    logic [1:0]        cnt_hi;
    logic [ADDR_W-1:0] cnt_full;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;
    logic [DATA_W-1:0] word;
    logic              busy_q;
    logic              err_q;

    assign in_ready  = (state != S_WRITE);
    assign acc       = in_valid & in_ready;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign sum_chk   = sum + in_data;
    assign cnt_full  = ADDR_W'({cnt_hi, in_data});

    assign mem_addr  = addr;
    assign mem_data  = word;
    assign mem_we    = (state == S_WRITE);
    assign busy      = busy_q;
    assign done      = (state == S_DONE);
    assign error     = err_q;
    assign cpu_reset = busy_q | err_q;

`ifdef PROG_LOADER_TIMEOUT_EN
    logic tmr_run;

    assign tmr_run = (state != S_IDLE) && (state != S_DONE)
                  && (state != S_ERR);

    prog_loader_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (tmr_run),
        .clr     (acc),
        .expired (tmo)
    );
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (acc && is_sync) nxt = S_CNT_HI;
            S_CNT_HI: if (acc) nxt = (in_data[7:2] != 6'd0) ? S_ERR : S_CNT_LO;
            S_CNT_LO: if (acc) nxt = (cnt_full == '0) ? S_CHECK : S_B2;
            S_B2:     if (acc) nxt = S_B1;
            S_B1:     if (acc) nxt = S_B0;
            S_B0:     if (acc) nxt = S_WRITE;
            S_WRITE:  nxt = (rem == ADDR_W'(1)) ? S_CHECK : S_B2;
            S_CHECK:  if (acc) nxt = (sum_chk == 8'd0) ? S_DONE : S_ERR;
            S_DONE:   nxt = S_IDLE;
            S_ERR:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (tmo) nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sum    <= '0;
            cnt_hi <= '0;
            addr   <= '0;
            rem    <= '0;
            word   <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && acc && is_sync) begin
                sum    <= '0;
                busy_q <= 1'b1;
                err_q  <= 1'b0;
            end
            // every byte after SYNC except CHK feeds the running sum
            if (acc && state inside {S_CNT_HI, S_CNT_LO, S_B2, S_B1, S_B0})
                sum <= sum_chk;
            if (acc && state == S_CNT_HI)
                cnt_hi <= in_data[1:0];
            if (acc && state == S_CNT_LO) begin
                rem  <= cnt_full;
                addr <= '0;
            end
            if (acc && state == S_B2) word[17:16] <= in_data[1:0];
            if (acc && state == S_B1) word[15:8]  <= in_data;
            if (acc && state == S_B0) word[7:0]   <= in_data;
            if (state == S_WRITE) begin
                addr <= addr + ADDR_W'(1);
                rem  <= rem - ADDR_W'(1);
            end
            if (nxt == S_DONE || nxt == S_ERR)
                busy_q <= 1'b0;
            if (nxt == S_ERR)
                err_q <= 1'b1;
        end
    end

endmodule
